// File: rtl/nibble_serial_adder_ctrl.sv
// Wide signed add/subtract sequenced through one external 4-bit adder slice,
// least-significant nibble first, with valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [3:0]       slice_a_o,
   output logic [3:0]       slice_b_o,
   output logic             slice_cin_o,
   input  logic [3:0]       slice_sum_i,
   input  logic             slice_cout_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IdxW = $clog2(NIB);

   typedef logic [IdxW-1:0] idx_t;
   localparam idx_t IdxLast = idx_t'(NIB - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q, state_d;
   idx_t                  idx_q, idx_d;
   logic [NIB-1:0][3:0]   opa_q, opa_d;
   logic [NIB-1:0][3:0]   opb_q, opb_d;
   logic [NIB-1:0][3:0]   sum_q, sum_d;
   logic                  carry_q, carry_d;
   logic                  cout_q, cout_d;
   logic                  ovf_q, ovf_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_o  = 1'b0;
      busy_o      = 1'b0;
      out_valid_o = 1'b0;
      slice_a_o   = 4'h0;
      slice_b_o   = 4'h0;
      slice_cin_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready_o = !rst_i;
            if (in_valid_i) begin
               // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
               opa_d   = a_i;
               opb_d   = sub_i ? ~b_i : b_i;
               carry_d = sub_i;
               idx_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            busy_o         = 1'b1;
            slice_a_o      = opa_q[idx_q];
            slice_b_o      = opb_q[idx_q];
            slice_cin_o    = carry_q;
            sum_d[idx_q]   = slice_sum_i;
            carry_d        = slice_cout_i;
            idx_d          = idx_q + idx_t'(1);
            if (idx_q == IdxLast) begin
               idx_d   = '0;
               cout_d  = slice_cout_i;
               ovf_d   = (opa_q[NIB-1][3] == opb_q[NIB-1][3]) &&
                         (slice_sum_i[3] != opa_q[NIB-1][3]);
               state_d = StDone;
            end
         end
         StDone: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit signed add/subtract by time-multiplexing one external 4-bit adder slice, least-significant nibble first. The slice is our 4-bit carry-skip/ripple adder. The block accepts operands over a valid/ready handshake and drives the slice one nibble per cycle. It registers the inter-nibble carry, assembles the result and reports signed overflow over an output valid/ready handshake. It sits between the operand source and result consumer, letting a narrow adder serve a wide datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
NIB (localparam), WIDTH/4, number of nibble steps per operation

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
in_valid_i  input  1  operand request valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  operand A, two's complement
b_i  input  WIDTH  operand B, two's complement
sub_i  input  1  0 = A+B, 1 = A-B
slice_a_o  output  4  nibble of A to adder slice
slice_b_o  output  4  nibble of B' to adder slice, where B' = B, or ~B when subtracting
slice_cin_o  output  1  carry into adder slice
slice_sum_i  input  4  slice sum (bits 3:0), combinational from slice_* outputs
slice_cout_i  input  1  slice carry-out
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  result
cout_o  output  1  carry-out of bit WIDTH-1 (unsigned carry / not-borrow)
ovf_o  output  1  signed overflow
busy_o  output  1  operation in progress (state RUN)

Behaviour:
- Reset (rst_i high at clock edge) has the following effects:
  - State goes to IDLE and idx to 0.
  - Operand, carry, sum_o, cout_o and ovf_o registers go to 0.
  - out_valid_o and busy_o are 0.
  - in_ready_o = (state==IDLE) && !rst_i, so it reads 0 while rst_i is high and 1 in the first cycle after release.
- Reset mid-operation abandons the operation. No result is emitted.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i the block latches a_i into opA and (sub_i ? ~b_i : b_i) into opB, sets carry to sub_i and idx to 0, then goes to RUN.
  - in_valid_i low keeps the block in IDLE.
- RUN:
  - busy_o=1, in_ready_o=0.
  - Slice outputs are combinational from registers: slice_a_o=opA[4*idx+:4], slice_b_o=opB[4*idx+:4], slice_cin_o=carry.
  - At each edge the block writes sum[4*idx+:4] with slice_sum_i, sets carry to slice_cout_i and increments idx.
  - When idx==NIB-1 the following happen at that edge:
    - cout_o becomes slice_cout_i.
    - ovf_o becomes (opA[WIDTH-1]==opB[WIDTH-1]) && (slice_sum_i[3]!=opA[WIDTH-1]).
    - The state goes to DONE.
- DONE:
  - out_valid_o=1, in_ready_o=0, busy_o=0.
  - sum_o, cout_o and ovf_o are held stable.
  - On out_valid_o && out_ready_i the block returns to IDLE. out_valid_o drops in the next cycle.
  - No accept occurs in the same cycle as the result handoff.
- Slice outputs are driven to 0 in IDLE and DONE.
- Latency: with the accept edge at T, RUN occupies NIB cycles and out_valid_o rises after edge T+NIB.
  - With WIDTH=16 that is 4 cycles of RUN.
  - Minimum period between accepts is NIB+2 cycles.
- sum_o, cout_o and ovf_o keep their last result after the handoff, until the next result is written. Their values are only meaningful while out_valid_o=1.
- Input changes on a_i/b_i/sub_i after accept have no effect.
- in_valid_i is ignored while in RUN or DONE.
- Arithmetic: sum_o = (A + B' + sub_i) mod 2^WIDTH.

Test Plan:
- WIDTH=16, A=0x7FFF, B=0x0001, sub=0 -> sum_o=0x8000, cout_o=0, ovf_o=1; out_valid_o rises 4 cycles after accept.
- A=0xFFFF, B=0x0001, sub=0 -> sum_o=0x0000, cout_o=1, ovf_o=0; slice_cin_o sequence 0,1,1,1 across RUN cycles.
- A=0x0005, B=0x0007, sub=1 -> sum_o=0xFFFE, cout_o=0, ovf_o=0; A=0x8000, B=0x0001, sub=1 -> sum_o=0x7FFF, cout_o=1, ovf_o=1.
- A=0x1234, B=0x4321, out_ready_i held low 5 cycles after out_valid_o -> sum_o=0x5555 held stable, in_ready_o=0 throughout, new in_valid_i ignored; accept after release, IDLE next cycle.
- rst_i asserted in the 3rd RUN cycle -> next cycle state IDLE, out_valid_o=0, busy_o=0, sum_o=0, slice_*=0; in_ready_o=1 in first cycle after rst_i drops; a following op completes correctly.
- Slice monitor for A=0xABCD, B=0x1234: slice_a_o = D,C,B,A and slice_b_o = 4,3,2,1 on consecutive RUN cycles; random 1000-op compare of sum_o, cout_o and ovf_o against a reference model for WIDTH=8 and 16.
